decode_stage: RTL
=================

# decode_stage

Second stage of the five-stage RV32I pipeline. Consumes `instrD` and `PCD` from the fetch stage and decodes the instruction into control signals. It reads the 32×32 register file, which it owns and which is written by the writeback stage, and generates the sign-extended immediate. All results are registered into the ID/EX pipeline register that feeds execute.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `instrD`  in  32  instruction from fetch
- `PCD`  in  32  PC of `instrD`
- `RegWriteW`  in  1  writeback enable
- `RdW`  in  5  writeback destination register
- `ResultW`  in  32  writeback data
- `FlushE`  in  1  synchronous bubble insert into ID/EX
- `RegWriteE`  out  1  register write enable, registered
- `ResultSrcE`  out  2  result select: 00 ALU, 01 memory, 10 PC+4
- `MemWriteE`  out  1  store enable
- `JumpE`  out  1  jal
- `BranchE`  out  1  beq
- `ALUSrcE`  out  1  ALU operand B select: 1 = immediate, 0 = RD2
- `ALUControlE`  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- `RD1E`, `RD2E`  out  32  register operands
- `ImmExtE`  out  32  sign-extended immediate
- `PCE`, `PCplus4E`  out  32  PC and PC+4
- `Rs1E`, `Rs2E`, `RdE`  out  5  register indices, for the hazard unit

## Operation
Field extraction from `instrD`:
- opcode = [6:0]
- rd = [11:7]
- funct3 = [14:12]
- rs1 = [19:15]
- rs2 = [24:20]
- funct7b5 = [30]

Main decode. Fields are RegWrite / ImmSrc / ALUSrc / MemWrite / ResultSrc / Branch / ALUOp / Jump.
- 0000011 lw: 1 / I / 1 / 0 / 01 / 0 / 00 / 0
- 0100011 sw: 0 / S / 1 / 1 / 00 / 0 / 00 / 0
- 0110011 R-type: 1 / – / 0 / 0 / 00 / 0 / 10 / 0
- 1100011 beq: 0 / B / 0 / 0 / 00 / 1 / 01 / 0
- 0010011 I-ALU: 1 / I / 1 / 0 / 00 / 0 / 10 / 0
- 1101111 jal: 1 / J / – / 0 / 10 / 0 / – / 1
- 0110111 lui: 1 / U / 1 / 0 / 00 / 0 / 00 / 0. Operand A is forced to zero by execute (`Rs1E` = 0 via rs1 field masking).
- Any other opcode, including 0x00000000: all controls 0, i.e. a NOP.

ALU decode:
- ALUOp 00 → add.
- ALUOp 01 → sub.
- ALUOp 10, funct3 000 → sub if opcode[5] & funct7b5, else add.
- ALUOp 10, funct3 010 → slt; 110 → or; 111 → and.
- ALUOp 10, any other funct3 → add.

Immediates, all sign-extended from instr[31]:
- I: [31:20]
- S: {[31:25], [11:7]}
- B: {[31], [7], [30:25], [11:8], 0}
- J: {[31], [19:12], [20], [30:21], 0}
- U: {[31:12], 12'b0}
- No immediate type: 0.

Register file:
- 32×32 bits; x0 always reads 0.
- Writes are ignored when `RdW` = 0.
- Writes occur on the rising edge when `RegWriteW` = 1.
- Write-through bypass: if `RegWriteW` = 1 and `RdW` = rs ≠ 0, that read port returns `ResultW` in the same cycle.

PC+4 is computed as `PCD` + 4, modulo 2^32.

For lui, `Rs1E` is registered as 0.

## Timing
- Decode, register read and immediate generation are combinational from `instrD`.
- The ID/EX register captures on the rising edge, so outputs appear exactly 1 cycle after `instrD`/`PCD`.
- Reset (asynchronous): every ID/EX output = 0, and all 32 registers = 0. The block stays at 0 while `rst` is high, including when `rst` is asserted mid-instruction.
- `FlushE` = 1 at the rising edge: every ID/EX output = 0 on the next cycle; the register file is unaffected. Flush has priority over the incoming decode.
- A register file write and an ID/EX capture in the same edge are both performed; the captured RD value is the bypassed `ResultW`.
- No stall input: ID/EX captures every cycle.

## Test plan
- Reset: assert `rst` mid-run → all E outputs 0; after release, `addi x1,x0,5` (0x00500093) → `RegWriteE`=1, `ALUSrcE`=1, `ALUControlE`=000, `ImmExtE`=5, `RdE`=1 one cycle later.
- Bypass: `RegWriteW`=1, `RdW`=3, `ResultW`=0xDEADBEEF, with `add x4,x3,x3` (0x00318233) in decode → `RD1E`=`RD2E`=0xDEADBEEF. A write with `RdW`=0 → `RD1E` for `add x4,x0,x0` = 0.
- Immediates:
  - `sw x2,-4(x1)` (0xFE20AE23) → `ImmExtE`=0xFFFFFFFC, `MemWriteE`=1, `RegWriteE`=0.
  - `beq x0,x0,-8` (0xFE000CE3) → `ImmExtE`=0xFFFFFFF8, `BranchE`=1, `ALUControlE`=001.
- jal/lui:
  - `jal x1,0x800` (0x001000EF… J-encoded 2048) → `JumpE`=1, `ResultSrcE`=10, `PCplus4E`=`PCD`+4. Also check `PCD`=0xFFFFFFFC → `PCplus4E`=0.
  - `lui x5,0x12345` → `ImmExtE`=0x12345000.
- Flush and illegal opcodes: `FlushE`=1 on a valid `add` → next-cycle outputs all 0. Opcode 0x7F → all controls 0.
- ALU decode: `sub` (funct7b5=1, R-type) → 001; `addi` with imm[10]=1 (funct7b5=1, I-type) → 000; `slt` → 101; `or` → 011; `and` → 010.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: control decode, register file with write-through bypass, immediate generation.
// All results registered into ID/EX one cycle after instrD/PCD; no stall, FlushE inserts a bubble.
module decode_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instrD,
   input  logic [31:0] PCD,
   input  logic        RegWriteW,
   input  logic [4:0]  RdW,
   input  logic [31:0] ResultW,
   input  logic        FlushE,
   output logic        RegWriteE,
   output logic [1:0]  ResultSrcE,
   output logic        MemWriteE,
   output logic        JumpE,
   output logic        BranchE,
   output logic        ALUSrcE,
   output logic [2:0]  ALUControlE,
   output logic [31:0] RD1E,
   output logic [31:0] RD2E,
   output logic [31:0] ImmExtE,
   output logic [31:0] PCE,
   output logic [31:0] PCplus4E,
   output logic [4:0]  Rs1E,
   output logic [4:0]  Rs2E,
   output logic [4:0]  RdE
);

   typedef enum logic [2:0] {
      IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J, IMM_U
   } immSrc_t;

   typedef struct packed {
      logic        regWrite;
      logic [1:0]  resultSrc;
      logic        memWrite;
      logic        jump;
      logic        branch;
      logic        aluSrc;
      logic [2:0]  aluControl;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] immExt;
      logic [31:0] pc;
      logic [31:0] pcPlus4;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } idEx_t;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        funct7b5;
   logic [4:0]  rs1, rs2, rd;

   assign opcode   = instrD[6:0];
   assign rd       = instrD[11:7];
   assign funct3   = instrD[14:12];
   assign rs2      = instrD[24:20];
   assign funct7b5 = instrD[30];

   logic        regWrite, aluSrc, memWrite, branch, jump, isLui;
   logic [1:0]  resultSrc, aluOp;
   immSrc_t     immSrc;

   always_comb begin
      regWrite  = 1'b0;
      immSrc    = IMM_NONE;
      aluSrc    = 1'b0;
      memWrite  = 1'b0;
      resultSrc = 2'b00;
      branch    = 1'b0;
      aluOp     = 2'b00;
      jump      = 1'b0;
      isLui     = 1'b0;
      case (opcode)
         7'b0000011: begin regWrite = 1'b1; immSrc = IMM_I; aluSrc = 1'b1; resultSrc = 2'b01; end
         7'b0100011: begin immSrc = IMM_S; aluSrc = 1'b1; memWrite = 1'b1; end
         7'b0110011: begin regWrite = 1'b1; aluOp = 2'b10; end
         7'b1100011: begin immSrc = IMM_B; branch = 1'b1; aluOp = 2'b01; end
         7'b0010011: begin regWrite = 1'b1; immSrc = IMM_I; aluSrc = 1'b1; aluOp = 2'b10; end
         7'b1101111: begin regWrite = 1'b1; immSrc = IMM_J; resultSrc = 2'b10; jump = 1'b1; end
         7'b0110111: begin regWrite = 1'b1; immSrc = IMM_U; aluSrc = 1'b1; isLui = 1'b1; end
         default: ;
      endcase
   end

   // lui reads x0 so execute's operand A is zero without a dedicated mux.
   assign rs1 = isLui ? 5'd0 : instrD[19:15];

   logic [2:0] aluControl;

   always_comb begin
      aluControl = 3'b000;
      case (aluOp)
         2'b01: aluControl = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  aluControl = (opcode[5] & funct7b5) ? 3'b001 : 3'b000;
               3'b010:  aluControl = 3'b101;
               3'b110:  aluControl = 3'b011;
               3'b111:  aluControl = 3'b010;
               default: aluControl = 3'b000;
            endcase
         end
         default: aluControl = 3'b000;
      endcase
   end

   logic [31:0] immExt;

   always_comb begin
      immExt = 32'd0;
      case (immSrc)
         IMM_I:   immExt = {{20{instrD[31]}}, instrD[31:20]};
         IMM_S:   immExt = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
         IMM_B:   immExt = {{20{instrD[31]}}, instrD[7], instrD[30:25], instrD[11:8], 1'b0};
         IMM_J:   immExt = {{12{instrD[31]}}, instrD[19:12], instrD[20], instrD[30:21], 1'b0};
         IMM_U:   immExt = {instrD[31:12], 12'd0};
         default: immExt = 32'd0;
      endcase
   end

   logic [31:0] regs [32];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      end else if (RegWriteW && (RdW != 5'd0)) begin
         regs[RdW] <= ResultW;
      end
   end

   // Write-through bypass so a same-cycle writeback is seen by the instruction in decode.
   logic [31:0] rd1, rd2;

   always_comb begin
      rd1 = 32'd0;
      rd2 = 32'd0;
      if (rs1 != 5'd0) rd1 = (RegWriteW && (RdW == rs1)) ? ResultW : regs[rs1];
      if (rs2 != 5'd0) rd2 = (RegWriteW && (RdW == rs2)) ? ResultW : regs[rs2];
   end

   idEx_t idExNext, idEx;

   always_comb begin
      idExNext            = '0;
      idExNext.regWrite   = regWrite;
      idExNext.resultSrc  = resultSrc;
      idExNext.memWrite   = memWrite;
      idExNext.jump       = jump;
      idExNext.branch     = branch;
      idExNext.aluSrc     = aluSrc;
      idExNext.aluControl = aluControl;
      idExNext.rd1        = rd1;
      idExNext.rd2        = rd2;
      idExNext.immExt     = immExt;
      idExNext.pc         = PCD;
      idExNext.pcPlus4    = PCD + 32'd4;
      idExNext.rs1        = rs1;
      idExNext.rs2        = rs2;
      idExNext.rd         = rd;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         idEx <= '0;
      else if (FlushE) idEx <= '0;
      else             idEx <= idExNext;
   end

   assign RegWriteE   = idEx.regWrite;
   assign ResultSrcE  = idEx.resultSrc;
   assign MemWriteE   = idEx.memWrite;
   assign JumpE       = idEx.jump;
   assign BranchE     = idEx.branch;
   assign ALUSrcE     = idEx.aluSrc;
   assign ALUControlE = idEx.aluControl;
   assign RD1E        = idEx.rd1;
   assign RD2E        = idEx.rd2;
   assign ImmExtE     = idEx.immExt;
   assign PCE         = idEx.pc;
   assign PCplus4E    = idEx.pcPlus4;
   assign Rs1E        = idEx.rs1;
   assign Rs2E        = idEx.rs2;
   assign RdE         = idEx.rd;

endmodule
